// File: rtl/player_executor_if.sv
// player_executor_if: instruction stream in, authoritative player state out.
// master = instruction issuer / observer, slave = player_executor.
interface player_executor_if;
    logic [15:0] playerInstruction;
    logic        isMove;
    logic [9:0]  playerX;
    logic [9:0]  playerY;
    logic [7:0]  playerHP;
    logic        isDeath;
    logic        invincible;

    modport master (
        output playerInstruction, isMove,
        input  playerX, playerY, playerHP, isDeath, invincible
    );

    modport slave (
        input  playerInstruction, isMove,
        output playerX, playerY, playerHP, isDeath, invincible
    );
endinterface

// File: rtl/player_executor.sv
// player_executor: soul position, HP and death state driven by playerInstruction.
// Define PLAYER_IFRAME_EN to enable post-hit invincibility frames.
module player_executor #(
    parameter int MAX_HP        = 100,
    parameter int MOVE_DIV      = 4,
    parameter int STEP          = 2,
    parameter int BOX_X0        = 200,
    parameter int BOX_X1        = 440,
    parameter int BOX_Y0        = 240,
    parameter int BOX_Y1        = 400,
    parameter int START_X       = 320,
    parameter int START_Y       = 320,
    parameter int IFRAME_CYCLES = 30
) (
    input logic              clk,
    input logic              rst_n,
    player_executor_if.slave bus
);
    localparam logic [3:0]  OP_HPY  = 4'd1;
    localparam logic [3:0]  OP_DPY  = 4'd2;
    localparam logic [3:0]  OP_MOV  = 4'd5;
    localparam logic [3:0]  OP_SHP  = 4'd6;
    localparam logic [1:0]  CNT_MAX = 2'(MOVE_DIV - 1);
    localparam logic [10:0] X0      = 11'(BOX_X0);
    localparam logic [10:0] X1      = 11'(BOX_X1);
    localparam logic [10:0] Y0      = 11'(BOX_Y0);
    localparam logic [10:0] Y1      = 11'(BOX_Y1);
    localparam logic [10:0] STP     = 11'(STEP);
    localparam logic [9:0]  SX      = 10'(START_X);
    localparam logic [9:0]  SY      = 10'(START_Y);
    localparam logic [8:0]  HMAX    = 9'(MAX_HP);

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  hp_q, hp_d, dir_q, dir_d;
    logic [1:0]  cnt_q, cnt_d, cnt_eff;
    logic        dead_q, dead_d, armed_q;
    logic        hp_op, exec, mv_act, inv;
    logic        ifr_load, ifr_clear;
    logic [3:0]  op;
    logic [7:0]  opd;
    logic [8:0]  hsum;
    logic [10:0] xe, ye;
    logic        unused_bits;

    assign op      = bus.playerInstruction[15:12];
    assign opd     = bus.playerInstruction[11:4];
    assign hp_op   = (op == OP_HPY) || (op == OP_DPY) || (op == OP_SHP);
    assign exec    = hp_op && armed_q;
    assign mv_act  = bus.isMove && (op == OP_MOV) && !dead_q;
    // a direction change restarts the step period from zero
    assign cnt_eff = (opd == dir_q) ? cnt_q : 2'd0;
    assign xe      = {1'b0, x_q};
    assign ye      = {1'b0, y_q};
    assign hsum    = {1'b0, hp_q} + {1'b0, opd};

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        cnt_d     = 2'd0;
        hp_d      = hp_q;
        dead_d    = dead_q;
        ifr_load  = 1'b0;
        ifr_clear = 1'b0;
        if (mv_act) begin
            dir_d = opd;
            cnt_d = cnt_eff + 2'd1;
            if (cnt_eff == CNT_MAX) begin
                cnt_d = 2'd0;
                case (opd)
                    8'd0: y_d = (ye < Y0 + STP) ? Y0[9:0] : y_q - STP[9:0];
                    8'd1: x_d = (xe < X0 + STP) ? X0[9:0] : x_q - STP[9:0];
                    8'd2: y_d = (ye + STP > Y1) ? Y1[9:0] : y_q + STP[9:0];
                    8'd3: x_d = (xe + STP > X1) ? X1[9:0] : x_q + STP[9:0];
                    default: ;
                endcase
            end
        end
        if (exec) begin
            case (op)
                OP_HPY: begin
                    if (!dead_q)
                        hp_d = (hsum > HMAX) ? HMAX[7:0] : hsum[7:0];
                end
                OP_DPY: begin
                    // a dropped hit still consumes the arm
                    if (!dead_q && !inv) begin
                        hp_d     = (opd >= hp_q) ? 8'd0 : hp_q - opd;
                        dead_d   = (opd >= hp_q);
                        ifr_load = (opd != 8'd0);
                    end
                end
                OP_SHP: begin
                    hp_d = ({1'b0, opd} > HMAX) ? HMAX[7:0] : opd;
                    x_d  = SX;
                    y_d  = SY;
                    if (opd != 8'd0) begin
                        dead_d    = 1'b0;
                        ifr_clear = 1'b1;
                    end else begin
                        dead_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= SX;
            y_q     <= SY;
            hp_q    <= HMAX[7:0];
            dead_q  <= 1'b0;
            armed_q <= 1'b1;
            cnt_q   <= 2'd0;
            dir_q   <= 8'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hp_q    <= hp_d;
            dead_q  <= dead_d;
            armed_q <= !hp_op;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

`ifdef PLAYER_IFRAME_EN
    localparam int IW = $clog2(IFRAME_CYCLES + 1);
    logic [IW-1:0] ifr_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ifr_q <= '0;
        else if (ifr_clear)
            ifr_q <= '0;
        else if (ifr_load)
            ifr_q <= IW'(IFRAME_CYCLES);
        else if (ifr_q != '0)
            ifr_q <= ifr_q - IW'(1);
    end

    assign inv         = (ifr_q != '0);
    assign unused_bits = &{1'b0, bus.playerInstruction[3:0]};
`else
    assign inv         = 1'b0;
    assign unused_bits = &{1'b0, ifr_load, ifr_clear,
                           bus.playerInstruction[3:0],
                           32'(IFRAME_CYCLES)};
`endif

    assign bus.playerX    = x_q;
    assign bus.playerY    = y_q;
    assign bus.playerHP   = hp_q;
    assign bus.isDeath    = dead_q;
    assign bus.invincible = inv;
endmodule

// File: tb/tb_player_executor.sv
// tb_player_executor: directed vector table plus randomized run
// against a behavioural model of the player rules.
module tb_player_executor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_executor_if bus();
    player_executor dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

`ifdef PLAYER_IFRAME_EN
    localparam int IFR = 30;
`else
    localparam int IFR = 0;
`endif

    int total = 0;
    int bad = 0;

    int mx, my, mhp, mif, mrun, mdir;
    bit mdead, mdisarm;

    typedef struct {
        int op; int opd; bit mv; int n;
        int hp; int x; int y; bit dead;
    } vec_t;
    vec_t vecs[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 320; mhp = 100; mif = 0;
        mrun = 0; mdir = 0; mdead = 0; mdisarm = 0;
    endtask

    // state after one clock edge with the given instruction applied
    task automatic model_step(int op, int opd, bit mv);
        bit act, inv, hpop;
        int nif;
        inv = (mif > 0);
        nif = (mif > 0) ? mif - 1 : 0;
        act = mv && (op == 5) && !mdead;
        if (act) begin
            mrun = (mrun > 0 && opd == mdir) ? mrun + 1 : 1;
            mdir = opd;
            if (mrun % 4 == 0) begin
                case (opd)
                    0: my = (my - 2 < 240) ? 240 : my - 2;
                    1: mx = (mx - 2 < 200) ? 200 : mx - 2;
                    2: my = (my + 2 > 400) ? 400 : my + 2;
                    3: mx = (mx + 2 > 440) ? 440 : mx + 2;
                    default: ;
                endcase
            end
        end else begin
            mrun = 0;
        end
        hpop = (op == 1) || (op == 2) || (op == 6);
        if (hpop && !mdisarm) begin
            if (op == 1 && !mdead) begin
                mhp = (mhp + opd > 100) ? 100 : mhp + opd;
            end else if (op == 2 && !mdead && !inv) begin
                mhp = (opd >= mhp) ? 0 : mhp - opd;
                if (opd > 0 && IFR > 0) nif = IFR;
                if (mhp == 0) mdead = 1;
            end else if (op == 6) begin
                mhp = (opd > 100) ? 100 : opd;
                mx = 320; my = 320;
                if (opd > 0) begin
                    mdead = 0; nif = 0;
                end
                if (mhp == 0) mdead = 1;
            end
        end
        mdisarm = hpop;
        mif = nif;
    endtask

    task automatic step(int op, int opd, bit mv);
        logic [3:0] o4;
        logic [7:0] d8;
        o4 = op[3:0];
        d8 = opd[7:0];
        bus.playerInstruction = {o4, d8, 4'd0};
        bus.isMove = mv;
        @(posedge clk);
        #1;
        model_step(op, opd, mv);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.playerInstruction = 16'd0;
        bus.isMove = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic check_model(string tag);
        check({tag, "_x"}, 32'(bus.playerX), mx);
        check({tag, "_y"}, 32'(bus.playerY), my);
        check({tag, "_hp"}, 32'(bus.playerHP), mhp);
        check({tag, "_dead"}, 32'(bus.isDeath), 32'(mdead));
        check({tag, "_inv"}, 32'(bus.invincible), 32'(mif > 0));
    endtask

    initial begin
        int op, opd, hold;
        bit mv;
        bus.playerInstruction = 16'd0;
        bus.isMove = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", 32'(bus.playerX), 320);
        check("rst_y", 32'(bus.playerY), 320);
        check("rst_hp", 32'(bus.playerHP), 100);
        check("rst_dead", 32'(bus.isDeath), 0);
        check("rst_inv", 32'(bus.invincible), 0);
        model_reset();
        rst_n = 1'b1;

        step(2, 30, 0);
        check("dpy_first_edge", 32'(bus.playerHP), 70);
        check("dpy_inv", 32'(bus.invincible), 32'(IFR > 0));

        vecs.push_back('{2, 30, 0, 9, 70, 320, 320, 0});
        vecs.push_back('{0, 0, 0, 1, 70, 320, 320, 0});
        vecs.push_back('{2, 30, 0, 1, (IFR > 0) ? 70 : 40, 320, 320, 0});
        vecs.push_back('{0, 0, 0, 1, (IFR > 0) ? 70 : 40, 320, 320, 0});
        vecs.push_back('{1, 200, 0, 2, 100, 320, 320, 0});
        vecs.push_back('{0, 0, 0, 40, 100, 320, 320, 0});
        vecs.push_back('{2, 150, 0, 1, 0, 320, 320, 1});
        vecs.push_back('{0, 0, 0, 1, 0, 320, 320, 1});
        vecs.push_back('{5, 3, 1, 20, 0, 320, 320, 1});
        vecs.push_back('{6, 100, 0, 1, 100, 320, 320, 0});
        vecs.push_back('{0, 0, 0, 1, 100, 320, 320, 0});
        vecs.push_back('{5, 3, 1, 3, 100, 320, 320, 0});
        vecs.push_back('{5, 3, 1, 1, 100, 322, 320, 0});
        vecs.push_back('{5, 3, 1, 4, 100, 324, 320, 0});
        vecs.push_back('{5, 3, 0, 8, 100, 324, 320, 0});
        vecs.push_back('{5, 7, 1, 8, 100, 324, 320, 0});
        vecs.push_back('{5, 0, 1, 400, 100, 324, 240, 0});
        vecs.push_back('{5, 1, 1, 300, 100, 200, 240, 0});
        vecs.push_back('{5, 3, 1, 500, 100, 440, 240, 0});
        vecs.push_back('{5, 2, 1, 400, 100, 440, 400, 0});

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++)
                step(vecs[i].op, vecs[i].opd, vecs[i].mv);
            check($sformatf("vec%0d_hp", i), 32'(bus.playerHP), vecs[i].hp);
            check($sformatf("vec%0d_x", i), 32'(bus.playerX), vecs[i].x);
            check($sformatf("vec%0d_y", i), 32'(bus.playerY), vecs[i].y);
            check($sformatf("vec%0d_dead", i), 32'(bus.isDeath),
                  32'(vecs[i].dead));
        end

        do_reset();
        check_model("after_rst");
        for (int c = 0; c < 3000; c += hold) begin
            case ($urandom_range(0, 9))
                0: op = 0;
                1: op = 1;
                2, 3: op = 2;
                4, 5, 6: op = 5;
                7: op = 6;
                8: op = $urandom_range(3, 4);
                default: op = $urandom_range(7, 15);
            endcase
            case (op)
                1: opd = $urandom_range(0, 60);
                2: opd = $urandom_range(0, 70);
                5: opd = $urandom_range(0, 4);
                6: opd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
                default: opd = $urandom_range(0, 255);
            endcase
            mv = ($urandom_range(0, 4) != 0);
            hold = (op == 5) ? $urandom_range(1, 40) : $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) begin
                step(op, opd, mv);
                check_model("rnd");
            end
        end

        step(0, 0, 0);
        step(6, 100, 0);
        step(0, 0, 0);
        step(2, 10, 0);
        step(5, 3, 1);
        step(5, 3, 1);
        check_model("pre_rst");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_x", 32'(bus.playerX), 320);
        check("mid_rst_y", 32'(bus.playerY), 320);
        check("mid_rst_hp", 32'(bus.playerHP), 100);
        check("mid_rst_dead", 32'(bus.isDeath), 0);
        check("mid_rst_inv", 32'(bus.invincible), 0);
        model_reset();
        rst_n = 1'b1;
        step(5, 3, 1);
        step(5, 3, 1);
        step(5, 3, 1);
        check("post_rst_hold_x", 32'(bus.playerX), 320);
        step(5, 3, 1);
        check("post_rst_step_x", 32'(bus.playerX), 322);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
